// File: rtl/axi_mux_resp_tracker.sv
// AXI mux response-path tracker: decodes the owning upstream port from the response ID,
// forwards beats through one register stage and tracks outstanding transactions per port.
module axi_mux_resp_tracker #(
  parameter int unsigned NoSlvPorts   = 4,
  parameter int unsigned SlvIdWidth   = 4,
  parameter int unsigned CounterWidth = 4,
  parameter int unsigned PayloadWidth = 34,
  localparam int unsigned PortIdxW    = $clog2(NoSlvPorts),
  localparam int unsigned MstIdWidth  = SlvIdWidth + PortIdxW
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [PortIdxW-1:0]     req_port_i,
  output logic [NoSlvPorts-1:0]   full_o,
  output logic [NoSlvPorts-1:0]   occupied_o,
  input  logic                    mst_valid_i,
  output logic                    mst_ready_o,
  input  logic [MstIdWidth-1:0]   mst_id_i,
  input  logic                    mst_last_i,
  input  logic [PayloadWidth-1:0] mst_payload_i,
  output logic [NoSlvPorts-1:0]   slv_valid_o,
  input  logic [NoSlvPorts-1:0]   slv_ready_i,
  output logic [SlvIdWidth-1:0]   slv_id_o,
  output logic                    slv_last_o,
  output logic [PayloadWidth-1:0] slv_payload_o,
  output logic                    err_unexpected_o,
  output logic                    err_overflow_o
);

  logic [CounterWidth-1:0] cnt_q [NoSlvPorts];

  logic                    stage_full_q;
  logic [PortIdxW-1:0]     stage_port_q;
  logic [SlvIdWidth-1:0]   stage_id_q;
  logic                    stage_last_q;
  logic [PayloadWidth-1:0] stage_payload_q;
  logic                    err_unexpected_q;
  logic                    err_overflow_q;

  logic [PortIdxW-1:0]     in_port;
  logic                    in_owned;
  logic                    accept;
  logic                    load;
  logic                    unexpected;
  logic                    stage_ready;
  logic                    overflow;
  logic [NoSlvPorts-1:0]   inc;
  logic [NoSlvPorts-1:0]   dec;

  // Per-port status decoded straight from the counter registers.
  for (genvar g = 0; g < NoSlvPorts; g++) begin : g_status
    assign full_o[g]     = &cnt_q[g];
    assign occupied_o[g] = |cnt_q[g];
  end

  assign in_port = mst_id_i[MstIdWidth-1 -: PortIdxW];

  // Stage can take a new beat when empty or when its current beat leaves this cycle.
  always_comb begin
    stage_ready = 1'b0;
    for (int p = 0; p < NoSlvPorts; p++) begin
      if (stage_port_q == PortIdxW'(p)) stage_ready = slv_ready_i[p];
    end
  end

  assign mst_ready_o = ~stage_full_q | stage_ready;
  assign accept      = mst_valid_i & mst_ready_o;

  // Ownership uses the pre-update counter; out-of-range indices match no port.
  always_comb begin
    in_owned = 1'b0;
    for (int p = 0; p < NoSlvPorts; p++) begin
      if (in_port == PortIdxW'(p)) in_owned = occupied_o[p];
    end
  end

  assign load       = accept & in_owned;
  assign unexpected = accept & ~in_owned;

  always_comb begin
    inc      = '0;
    dec      = '0;
    overflow = 1'b0;
    for (int p = 0; p < NoSlvPorts; p++) begin
      inc[p]   = req_i & (req_port_i == PortIdxW'(p)) & ~full_o[p];
      dec[p]   = load & mst_last_i & (in_port == PortIdxW'(p));
      overflow = overflow | (req_i & (req_port_i == PortIdxW'(p)) & full_o[p]);
    end
  end

  // Outstanding counters: simultaneous issue and retire cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NoSlvPorts; p++) cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NoSlvPorts; p++) begin
        if (inc[p] && !dec[p]) begin
          cnt_q[p] <= cnt_q[p] + CounterWidth'(1);
        end else if (dec[p] && !inc[p]) begin
          cnt_q[p] <= cnt_q[p] - CounterWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_full_q    <= 1'b0;
      stage_port_q    <= '0;
      stage_id_q      <= '0;
      stage_last_q    <= 1'b0;
      stage_payload_q <= '0;
    end else if (load) begin
      stage_full_q    <= 1'b1;
      stage_port_q    <= in_port;
      stage_id_q      <= mst_id_i[SlvIdWidth-1:0];
      stage_last_q    <= mst_last_i;
      stage_payload_q <= mst_payload_i;
    end else if (stage_full_q && stage_ready) begin
      stage_full_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_unexpected_q <= 1'b0;
      err_overflow_q   <= 1'b0;
    end else begin
      err_unexpected_q <= unexpected;
      err_overflow_q   <= overflow;
    end
  end

  always_comb begin
    slv_valid_o = '0;
    for (int p = 0; p < NoSlvPorts; p++) begin
      if (stage_full_q && (stage_port_q == PortIdxW'(p))) slv_valid_o[p] = 1'b1;
    end
  end

  assign slv_id_o         = stage_id_q;
  assign slv_last_o       = stage_last_q;
  assign slv_payload_o    = stage_payload_q;
  assign err_unexpected_o = err_unexpected_q;
  assign err_overflow_o   = err_overflow_q;

endmodule

// File: tb/tb_axi_mux_resp_tracker.sv
// Directed bench for axi_mux_resp_tracker: issue/retire counting, stage stalls and error pulses.
module tb_axi_mux_resp_tracker;

  localparam int unsigned NoSlvPorts   = 4;
  localparam int unsigned SlvIdWidth   = 4;
  localparam int unsigned CounterWidth = 4;
  localparam int unsigned PayloadWidth = 34;
  localparam int unsigned PortIdxW     = 2;
  localparam int unsigned MstIdWidth   = 6;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    req_i;
  logic [PortIdxW-1:0]     req_port_i;
  logic [NoSlvPorts-1:0]   full_o;
  logic [NoSlvPorts-1:0]   occupied_o;
  logic                    mst_valid_i;
  logic                    mst_ready_o;
  logic [MstIdWidth-1:0]   mst_id_i;
  logic                    mst_last_i;
  logic [PayloadWidth-1:0] mst_payload_i;
  logic [NoSlvPorts-1:0]   slv_valid_o;
  logic [NoSlvPorts-1:0]   slv_ready_i;
  logic [SlvIdWidth-1:0]   slv_id_o;
  logic                    slv_last_o;
  logic [PayloadWidth-1:0] slv_payload_o;
  logic                    err_unexpected_o;
  logic                    err_overflow_o;

  int total  = 0;
  int passed = 0;

  axi_mux_resp_tracker #(
    .NoSlvPorts  (NoSlvPorts),
    .SlvIdWidth  (SlvIdWidth),
    .CounterWidth(CounterWidth),
    .PayloadWidth(PayloadWidth)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_i           (req_i),
    .req_port_i      (req_port_i),
    .full_o          (full_o),
    .occupied_o      (occupied_o),
    .mst_valid_i     (mst_valid_i),
    .mst_ready_o     (mst_ready_o),
    .mst_id_i        (mst_id_i),
    .mst_last_i      (mst_last_i),
    .mst_payload_i   (mst_payload_i),
    .slv_valid_o     (slv_valid_o),
    .slv_ready_i     (slv_ready_i),
    .slv_id_o        (slv_id_o),
    .slv_last_o      (slv_last_o),
    .slv_payload_o   (slv_payload_o),
    .err_unexpected_o(err_unexpected_o),
    .err_overflow_o  (err_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [1:0] port, input logic [3:0] id, input logic last,
                      input logic [PayloadWidth-1:0] pl);
    mst_valid_i   = 1'b1;
    mst_id_i      = {port, id};
    mst_last_i    = last;
    mst_payload_i = pl;
  endtask

  task automatic idle_beat();
    mst_valid_i = 1'b0;
    mst_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b0; req_port_i = '0; slv_ready_i = '1;
    mst_valid_i = 1'b0; mst_id_i = '0; mst_last_i = 1'b0; mst_payload_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    total++; if (slv_valid_o !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", slv_valid_o); else passed++;
    total++; if (mst_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", mst_ready_o); else passed++;
    total++; if (occupied_o !== 4'b0000 || full_o !== 4'b0000) $display("FAIL reset_counters got occ=%b full=%b exp=0000", occupied_o, full_o); else passed++;
    total++; if ({err_unexpected_o, err_overflow_o, slv_last_o} !== 3'b000 || slv_payload_o !== '0 || slv_id_o !== 4'h0)
      $display("FAIL reset_outputs got err=%b%b last=%b id=%h pl=%h exp=0", err_unexpected_o, err_overflow_o, slv_last_o, slv_id_o, slv_payload_o); else passed++;
  endtask

  task automatic test_b_beats();
    req_i = 1'b1; req_port_i = 2'd2;
    repeat (3) tick();
    req_i = 1'b0;
    total++; if (occupied_o !== 4'b0100) $display("FAIL t1_issue got=%b exp=0100", occupied_o); else passed++;
    for (int k = 1; k <= 3; k++) begin
      beat(2'd2, 4'h5, 1'b1, PayloadWidth'(k));
      tick();
      total++; if (slv_valid_o !== 4'b0100 || slv_id_o !== 4'h5 || slv_payload_o !== PayloadWidth'(k))
        $display("FAIL t1_beat%0d got v=%b id=%h pl=%h exp v=0100 id=5 pl=%h", k, slv_valid_o, slv_id_o, slv_payload_o, k); else passed++;
      total++; if (occupied_o[2] !== (k < 3)) $display("FAIL t1_occ%0d got=%b exp=%b", k, occupied_o[2], k < 3); else passed++;
    end
    idle_beat();
    tick();
    total++; if (slv_valid_o !== 4'b0000) $display("FAIL t1_drain got=%b exp=0000", slv_valid_o); else passed++;
  endtask

  task automatic test_r_burst_stall();
    req_i = 1'b1; req_port_i = 2'd1;
    tick();
    req_i = 1'b0;
    beat(2'd1, 4'h3, 1'b0, 34'h0A0);
    tick();
    total++; if (slv_valid_o !== 4'b0010 || slv_payload_o !== 34'h0A0) $display("FAIL t2_b0 got v=%b pl=%h exp v=0010 pl=0a0", slv_valid_o, slv_payload_o); else passed++;
    beat(2'd1, 4'h3, 1'b0, 34'h0A1);
    tick();
    beat(2'd1, 4'h3, 1'b0, 34'h0A2);
    slv_ready_i = 4'b1101;
    #1;
    total++; if (mst_ready_o !== 1'b0) $display("FAIL t2_stall_ready got=%b exp=0", mst_ready_o); else passed++;
    for (int s = 0; s < 2; s++) begin
      tick();
      total++; if (slv_valid_o !== 4'b0010 || slv_payload_o !== 34'h0A1 || slv_last_o !== 1'b0 || mst_ready_o !== 1'b0)
        $display("FAIL t2_hold%0d got v=%b pl=%h last=%b rdy=%b exp v=0010 pl=0a1 last=0 rdy=0", s, slv_valid_o, slv_payload_o, slv_last_o, mst_ready_o); else passed++;
    end
    slv_ready_i = 4'b1111;
    tick();
    total++; if (slv_payload_o !== 34'h0A2 || occupied_o[1] !== 1'b1) $display("FAIL t2_b2 got pl=%h occ=%b exp pl=0a2 occ=1", slv_payload_o, occupied_o[1]); else passed++;
    beat(2'd1, 4'h3, 1'b1, 34'h0A3);
    tick();
    total++; if (slv_payload_o !== 34'h0A3 || slv_last_o !== 1'b1 || occupied_o[1] !== 1'b0)
      $display("FAIL t2_b3 got pl=%h last=%b occ=%b exp pl=0a3 last=1 occ=0", slv_payload_o, slv_last_o, occupied_o[1]); else passed++;
    idle_beat();
    tick();
  endtask

  task automatic test_unexpected();
    beat(2'd3, 4'h0, 1'b1, 34'h3FF);
    #1;
    total++; if (mst_ready_o !== 1'b1) $display("FAIL t3_ready got=%b exp=1", mst_ready_o); else passed++;
    tick();
    idle_beat();
    total++; if (slv_valid_o !== 4'b0000 || err_unexpected_o !== 1'b1) $display("FAIL t3_drop got v=%b err=%b exp v=0000 err=1", slv_valid_o, err_unexpected_o); else passed++;
    tick();
    total++; if (err_unexpected_o !== 1'b0 || occupied_o !== 4'b0000) $display("FAIL t3_pulse got err=%b occ=%b exp err=0 occ=0000", err_unexpected_o, occupied_o); else passed++;
  endtask

  task automatic test_overflow();
    req_i = 1'b1; req_port_i = 2'd0;
    repeat (14) tick();
    total++; if (full_o !== 4'b0000) $display("FAIL t4_not_full got=%b exp=0000", full_o); else passed++;
    tick();
    total++; if (full_o !== 4'b0001 || err_overflow_o !== 1'b0) $display("FAIL t4_full got full=%b ovf=%b exp full=0001 ovf=0", full_o, err_overflow_o); else passed++;
    tick();
    req_i = 1'b0;
    total++; if (err_overflow_o !== 1'b1 || full_o !== 4'b0001) $display("FAIL t4_ovf got ovf=%b full=%b exp ovf=1 full=0001", err_overflow_o, full_o); else passed++;
    tick();
    total++; if (err_overflow_o !== 1'b0) $display("FAIL t4_ovf_pulse got=%b exp=0", err_overflow_o); else passed++;
    // Retiring exactly 15 transactions proves the count held at 15.
    for (int k = 1; k <= 15; k++) begin
      beat(2'd0, 4'h1, 1'b1, PayloadWidth'(k));
      tick();
      if (k == 14) begin
        total++; if (occupied_o[0] !== 1'b1) $display("FAIL t4_drain14 got=%b exp=1", occupied_o[0]); else passed++;
      end
    end
    idle_beat();
    total++; if (occupied_o[0] !== 1'b0 || err_unexpected_o !== 1'b0) $display("FAIL t4_drain15 got occ=%b err=%b exp occ=0 err=0", occupied_o[0], err_unexpected_o); else passed++;
    tick();
  endtask

  task automatic test_same_cycle();
    req_i = 1'b1; req_port_i = 2'd1;
    tick();
    beat(2'd1, 4'h7, 1'b1, 34'h155);
    tick();
    req_i = 1'b0;
    idle_beat();
    total++; if (slv_valid_o !== 4'b0010 || slv_id_o !== 4'h7 || slv_payload_o !== 34'h155)
      $display("FAIL t5_fwd got v=%b id=%h pl=%h exp v=0010 id=7 pl=155", slv_valid_o, slv_id_o, slv_payload_o); else passed++;
    total++; if (occupied_o[1] !== 1'b1 || err_unexpected_o !== 1'b0 || err_overflow_o !== 1'b0)
      $display("FAIL t5_cnt got occ=%b eu=%b eo=%b exp occ=1 eu=0 eo=0", occupied_o[1], err_unexpected_o, err_overflow_o); else passed++;
    beat(2'd1, 4'h7, 1'b1, 34'h156);
    tick();
    idle_beat();
    total++; if (occupied_o[1] !== 1'b0 || err_unexpected_o !== 1'b0 || slv_payload_o !== 34'h156)
      $display("FAIL t5_retire got occ=%b eu=%b pl=%h exp occ=0 eu=0 pl=156", occupied_o[1], err_unexpected_o, slv_payload_o); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    req_i = 1'b1; req_port_i = 2'd2;
    tick();
    req_port_i = 2'd3;
    tick();
    req_i = 1'b0;
    slv_ready_i = 4'b1011;
    beat(2'd2, 4'h9, 1'b0, 34'h2AA);
    tick();
    idle_beat();
    total++; if (slv_valid_o !== 4'b0100 || mst_ready_o !== 1'b0) $display("FAIL t6_held got v=%b rdy=%b exp v=0100 rdy=0", slv_valid_o, mst_ready_o); else passed++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++; if (slv_valid_o !== 4'b0000 || occupied_o !== 4'b0000 || mst_ready_o !== 1'b1 || slv_payload_o !== '0)
      $display("FAIL t6_reset got v=%b occ=%b rdy=%b pl=%h exp v=0000 occ=0000 rdy=1 pl=0", slv_valid_o, occupied_o, mst_ready_o, slv_payload_o); else passed++;
    slv_ready_i = 4'b1111;
    tick();
  endtask

  initial begin
    test_reset();
    test_b_beats();
    test_r_burst_stall();
    test_unexpected();
    test_overflow();
    test_same_cycle();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
